alu_wb_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 46 ++++
 rtl/wb_skid_buf.sv | 76 +++++++
 rtl/alu_wb_stage.sv | 91 +++++++++
 tb/tb_alu_wb_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, status-bit layout and opcode-class predicates
// used by the EX->WB stage.
package alu_pkg;

    localparam logic [3:0] ALUC_ADDU    = 4'b0000;
    localparam logic [3:0] ALUC_SUBU    = 4'b0001;
    localparam logic [3:0] ALUC_ADD     = 4'b0010;
    localparam logic [3:0] ALUC_SUB     = 4'b0011;
    localparam logic [3:0] ALUC_AND     = 4'b0100;
    localparam logic [3:0] ALUC_OR      = 4'b0101;
    localparam logic [3:0] ALUC_XOR     = 4'b0110;
    localparam logic [3:0] ALUC_NOR     = 4'b0111;
    localparam logic [3:0] ALUC_LUI     = 4'b1000;
    localparam logic [3:0] ALUC_LUI_ALT = 4'b1001;
    localparam logic [3:0] ALUC_SLTU    = 4'b1010;
    localparam logic [3:0] ALUC_SLT     = 4'b1011;
    localparam logic [3:0] ALUC_SRA     = 4'b1100;
    localparam logic [3:0] ALUC_SRL     = 4'b1101;
    localparam logic [3:0] ALUC_SLL     = 4'b1110;
    localparam logic [3:0] ALUC_SLL_ALT = 4'b1111;

    // status = {zero, carry, negative, overflow}
    localparam int STATUS_ZERO  = 3;
    localparam int STATUS_CARRY = 2;
    localparam int STATUS_NEG   = 1;
    localparam int STATUS_OVF   = 0;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    function automatic logic aluc_sets_carry(input logic [3:0] aluc);
        case (aluc)
            ALUC_ADDU, ALUC_SUBU, ALUC_SLTU, ALUC_SRA,
            ALUC_SRL, ALUC_SLL, ALUC_SLL_ALT: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic aluc_sets_overflow(input logic [3:0] aluc);
        return (aluc == ALUC_ADD) || (aluc == ALUC_SUB);
    endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry valid/ready skid buffer; 1-cycle latency when empty, strict FIFO order.
// in_rdy is a flop (low only when both entries are full), so it never depends on out_rdy.
module wb_skid_buf
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_rdy_q, in_rdy_d;
    logic         acc, xfer;

    assign acc     = in_vld & in_rdy_q;
    assign xfer    = (state_q != BUF_EMPTY) & out_rdy;
    assign in_rdy  = in_rdy_q;
    assign out_vld = (state_q != BUF_EMPTY);
    assign out_dat = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (acc) begin
                    state_d = BUF_ONE;
                    main_d  = in_dat;
                end
            end
            BUF_ONE: begin
                if (acc && xfer) begin
                    main_d = in_dat;
                end else if (acc) begin
                    state_d = BUF_TWO;
                    skid_d  = in_dat;
                end else if (xfer) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (xfer) begin
                    state_d = BUF_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        in_rdy_d = (state_d != BUF_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BUF_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            in_rdy_q <= in_rdy_d;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// EX->WB stage: skid-buffered ALU result, status-flag register and add/sub overflow trap.
// 1-cycle latency when empty; in_ready is registered and drops only when both entries hold data.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_r,
    input  logic          in_zero,
    input  logic          in_carry,
    input  logic          in_negative,
    input  logic          in_overflow,
    input  logic [3:0]    in_aluc,
    input  logic [RW-1:0] in_rd,
    input  logic          in_wen,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_rd,
    output logic          out_wen,
    output logic [3:0]    status,
    output logic          ovf_sticky,
    input  logic          sticky_clr,
    output logic          trap
);

    localparam int PW = DW + RW + 1;

    logic          acc, tc, wen_eff;
    logic [PW-1:0] pay_in, pay_out;
    logic [3:0]    status_q, status_d;
    logic          ovf_sticky_q, ovf_sticky_d;
    logic          trap_q, trap_d;

    assign acc     = in_valid & in_ready;
    assign tc      = acc & in_overflow & aluc_sets_overflow(in_aluc);
    // The trapping instruction and any write to r0 must never reach the regfile.
    assign wen_eff = in_wen & ~tc & (in_rd != '0);
    assign pay_in  = {in_r, in_rd, wen_eff};

    wb_skid_buf #(.W(PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  (pay_in),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (pay_out)
    );

    assign {out_data, out_rd, out_wen} = pay_out;

    always_comb begin
        status_d = status_q;
        if (acc) begin
            status_d[STATUS_ZERO] = in_zero;
            status_d[STATUS_NEG]  = in_negative;
            if (aluc_sets_carry(in_aluc)) begin
                status_d[STATUS_CARRY] = in_carry;
            end
            if (aluc_sets_overflow(in_aluc)) begin
                status_d[STATUS_OVF] = in_overflow;
            end
        end
        ovf_sticky_d = tc | (ovf_sticky_q & ~sticky_clr);
        trap_d       = tc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q     <= '0;
            ovf_sticky_q <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            status_q     <= status_d;
            ovf_sticky_q <= ovf_sticky_d;
            trap_q       <= trap_d;
        end
    end

    assign status     = status_q;
    assign ovf_sticky = ovf_sticky_q;
    assign trap       = trap_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed vector table, hand sequences for back-pressure,
// sticky clear and mid-flight reset, then randomized traffic against a queue model.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_r;
    logic        in_zero, in_carry, in_negative, in_overflow;
    logic [3:0]  in_aluc;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [3:0]  status;
    logic        ovf_sticky, sticky_clr, trap;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    alu_wb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r),
        .in_zero(in_zero), .in_carry(in_carry), .in_negative(in_negative),
        .in_overflow(in_overflow), .in_aluc(in_aluc), .in_rd(in_rd), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wen(out_wen), .status(status),
        .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr), .trap(trap)
    );

    typedef struct {
        logic [3:0]  aluc;
        logic [31:0] r;
        logic [3:0]  flags;      // {z,c,n,v}
        logic [4:0]  rd;
        logic        wen;
        logic        exp_wen;
        logic [3:0]  exp_status;
        logic        exp_trap;
        logic        exp_sticky;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
    } item_t;

    vec_t  vecs [10];
    item_t mq [$];
    logic [3:0] m_status;
    logic       m_sticky, m_trap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] aluc, input logic [31:0] r, input logic [3:0] fl,
                         input logic [4:0] rd, input logic wen);
        in_valid = 1'b1; in_aluc = aluc; in_r = r;
        {in_zero, in_carry, in_negative, in_overflow} = fl;
        in_rd = rd; in_wen = wen;
    endtask

    function automatic logic model_carry_op(input logic [3:0] a);
        return a inside {4'b0000, 4'b0001, 4'b1010, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    endfunction

    function automatic logic model_ovf_op(input logic [3:0] a);
        return a inside {4'b0010, 4'b0011};
    endfunction

    initial begin
        logic [31:0] got [$];
        logic [31:0] pend [$];
        int accepts;
        logic rdy_before, holding;

        rst = 1'b1; in_valid = 0; in_r = 0; in_zero = 0; in_carry = 0; in_negative = 0;
        in_overflow = 0; in_aluc = 0; in_rd = 0; in_wen = 0; out_ready = 0; sticky_clr = 0;

        vecs[0] = '{4'b0000, 32'hFFFFFFFF, 4'b0110, 5'd3,  1'b1, 1'b1, 4'b0110, 1'b0, 1'b0};
        vecs[1] = '{4'b0010, 32'h80000000, 4'b0011, 5'd5,  1'b1, 1'b0, 4'b0111, 1'b1, 1'b1};
        vecs[2] = '{4'b0001, 32'h00000005, 4'b0100, 5'd7,  1'b1, 1'b1, 4'b0101, 1'b0, 1'b1};
        vecs[3] = '{4'b0100, 32'h00000000, 4'b1000, 5'd8,  1'b1, 1'b1, 4'b1101, 1'b0, 1'b1};
        vecs[4] = '{4'b0110, 32'h00001234, 4'b0101, 5'd0,  1'b1, 1'b0, 4'b0101, 1'b0, 1'b1};
        vecs[5] = '{4'b0011, 32'h00000007, 4'b0100, 5'd9,  1'b1, 1'b1, 4'b0100, 1'b0, 1'b1};
        vecs[6] = '{4'b1010, 32'h00000001, 4'b0001, 5'd10, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[7] = '{4'b1100, 32'h80000000, 4'b0111, 5'd31, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b1};
        vecs[8] = '{4'b1001, 32'hFFFF0000, 4'b0011, 5'd2,  1'b1, 1'b1, 4'b0110, 1'b0, 1'b1};
        vecs[9] = '{4'b1111, 32'h00000000, 4'b1000, 5'd4,  1'b1, 1'b1, 4'b1000, 1'b0, 1'b1};

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_wen", out_wen, 0);
        check("rst_status", status, 0);
        check("rst_sticky", ovf_sticky, 0);
        check("rst_trap", trap, 0);
        step();
        rst = 1'b0;
        step();

        // Directed vector table, one item at a time through an empty buffer
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].aluc, vecs[i].r, vecs[i].flags, vecs[i].rd, vecs[i].wen);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_data", i), out_data, vecs[i].r);
            check($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
            check($sformatf("v%0d_wen", i), out_wen, vecs[i].exp_wen);
            check($sformatf("v%0d_status", i), status, vecs[i].exp_status);
            check($sformatf("v%0d_trap", i), trap, vecs[i].exp_trap);
            check($sformatf("v%0d_sticky", i), ovf_sticky, vecs[i].exp_sticky);
            step();
            check($sformatf("v%0d_drain", i), out_valid, 0);
            check($sformatf("v%0d_trap_end", i), trap, 0);
        end

        // Back-pressure: three items offered back-to-back, consumer stalled first
        pend = '{32'd1, 32'd2, 32'd3};
        accepts = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 3);
            if (pend.size() > 0) drive(4'b0101, pend[0], 4'b0000, 5'd6, 1'b1);
            else in_valid = 1'b0;
            if (out_valid && out_ready) got.push_back(out_data);
            rdy_before = in_ready;
            holding = in_valid;
            step();
            if (holding && rdy_before) begin
                void'(pend.pop_front());
                accepts++;
                if (accepts == 2) check("bp_ready_drop", in_ready, 0);
            end
        end
        in_valid = 1'b0;
        check("bp_count", got.size(), 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("bp_order%0d", k), (k < got.size()) ? got[k] : 32'hDEAD, k + 1);

        // Clear sticky, then clear collides with a SUB overflow accept
        sticky_clr = 1'b1;
        step();
        check("clr_alone0", ovf_sticky, 0);
        drive(4'b0011, 32'h7FFFFFFF, 4'b0001, 5'd12, 1'b1);
        step();
        in_valid = 1'b0;
        check("clr_vs_set", ovf_sticky, 1);
        check("clr_trap", trap, 1);
        check("clr_wen", out_wen, 0);
        sticky_clr = 1'b0;
        step();
        check("sticky_hold", ovf_sticky, 1);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("clr_alone1", ovf_sticky, 0);

        // Asynchronous reset while both entries are full
        out_ready = 1'b0;
        drive(4'b0000, 32'h11, 4'b0110, 5'd1, 1'b1);
        step();
        drive(4'b0010, 32'h22, 4'b0011, 5'd2, 1'b1);
        step();
        in_valid = 1'b0;
        check("two_ready", in_ready, 0);
        check("two_trap", trap, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready, 1);
        check("arst_status", status, 0);
        check("arst_trap", trap, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(4'b0001, 32'h33, 4'b0000, 5'd4, 1'b1);
        step();
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 32'h33);
        check("post_rst_trap", trap, 0);
        step();

        // Randomized traffic vs queue model
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        mq.delete();
        m_status = 0; m_sticky = 0; m_trap = 0;
        holding = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic acc, xfer, tc;
            check("r_in_ready", in_ready, mq.size() < 2);
            check("r_out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                check("r_data", out_data, mq[0].data);
                check("r_rd", out_rd, mq[0].rd);
                check("r_wen", out_wen, mq[0].wen);
            end
            check("r_status", status, m_status);
            check("r_sticky", ovf_sticky, m_sticky);
            check("r_trap", trap, m_trap);

            if (!holding) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_r = $urandom;
                in_aluc = 4'($urandom_range(0, 15));
                {in_zero, in_carry, in_negative, in_overflow} = 4'($urandom_range(0, 15));
                in_rd = 5'($urandom_range(0, 31));
                in_wen = ($urandom_range(0, 3) != 0);
            end
            out_ready  = ($urandom_range(0, 2) != 0);
            sticky_clr = ($urandom_range(0, 7) == 0);

            acc  = in_valid && (mq.size() < 2);
            xfer = (mq.size() > 0) && out_ready;
            tc   = acc && in_overflow && model_ovf_op(in_aluc);
            if (xfer) void'(mq.pop_front());
            if (acc) mq.push_back('{in_r, in_rd, in_wen && !tc && (in_rd != 0)});
            if (acc) begin
                m_status[3] = in_zero;
                m_status[1] = in_negative;
                if (model_carry_op(in_aluc)) m_status[2] = in_carry;
                if (model_ovf_op(in_aluc))   m_status[0] = in_overflow;
            end
            if (tc) m_sticky = 1'b1;
            else if (sticky_clr) m_sticky = 1'b0;
            m_trap = tc;
            holding = in_valid && !acc;
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
